// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS32 subset core: one ALU and one unified, wait-state-tolerant
// memory port shared across FETCH/DECODE/EXEC/MEM/WB, with halt on illegal code.
module mips_multicycle #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] PCOut,
  output logic [31:0]       ALUResultOut,
  output logic              retire,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] pc_reg, npc_reg;
  logic [31:0]       ir_reg, a_reg, b_reg, imm_reg, alu_reg, mdr_reg;
  logic [31:0]       regs [0:31];

  // Instruction fields, decoded from IR throughout DECODE..WB
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [4:0]  unused_shamt;

  assign opcode       = ir_reg[31:26];
  assign rs           = ir_reg[25:21];
  assign rt           = ir_reg[20:16];
  assign rd           = ir_reg[15:11];
  assign unused_shamt = ir_reg[10:6];
  assign funct        = ir_reg[5:0];
  assign imm16        = ir_reg[15:0];

  logic is_rtype, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_lui;
  logic zero_ext, is_legal;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_lui   = (opcode == OP_LUI);
  assign zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI);

  always_comb begin
    is_legal = 1'b0;
    case (opcode)
      OP_RTYPE: is_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                           (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  logic [31:0] ext_imm, rs_val, rt_val;

  assign ext_imm = zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
  assign rs_val  = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val  = (rt == 5'd0) ? 32'd0 : regs[rt];

  // Shared ALU; the B operand is the register for R-type and branch compares
  logic [31:0] op_b, alu_next;

  assign op_b = (is_rtype || is_beq || is_bne) ? b_reg : imm_reg;

  always_comb begin
    alu_next = a_reg + op_b;
    if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_next = a_reg - op_b;
        FN_AND:  alu_next = a_reg & op_b;
        FN_OR:   alu_next = a_reg | op_b;
        FN_SLT:  alu_next = ($signed(a_reg) < $signed(op_b)) ? 32'd1 : 32'd0;
        default: alu_next = a_reg + op_b;
      endcase
    end else begin
      case (opcode)
        OP_BEQ, OP_BNE: alu_next = a_reg - op_b;
        OP_ANDI:        alu_next = a_reg & op_b;
        OP_ORI:         alu_next = a_reg | op_b;
        OP_SLTI:        alu_next = ($signed(a_reg) < $signed(op_b)) ? 32'd1 : 32'd0;
        OP_LUI:         alu_next = {imm16, 16'h0000};
        default:        alu_next = a_reg + op_b;
      endcase
    end
  end

  logic              branch_taken, jr_misaligned, ea_misaligned;
  logic [ADDR_W-1:0] branch_target, jump_target, jump_mask;

  assign branch_taken  = (is_beq && (a_reg == b_reg)) || (is_bne && (a_reg != b_reg));
  assign branch_target = npc_reg + ADDR_W'({imm_reg[29:0], 2'b00});
  assign jump_mask     = ADDR_W'(32'h0FFF_FFFF);
  assign jump_target   = (npc_reg & ~jump_mask) | (ADDR_W'({ir_reg[25:0], 2'b00}) & jump_mask);
  assign jr_misaligned = (a_reg[1:0] != 2'b00);
  assign ea_misaligned = (alu_next[1:0] != 2'b00);

  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  assign wb_dst  = is_jal ? 5'd31 : (is_rtype ? rd : rt);
  assign wb_data = is_lw  ? mdr_reg :
                   is_lui ? {imm16, 16'h0000} :
                   is_jal ? 32'(npc_reg) : alu_reg;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc_reg;
    mem_wdata  = b_reg;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = is_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_beq || is_bne || is_j) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (is_jr) begin
          retire     = !jr_misaligned;
          state_next = jr_misaligned ? S_HALT : S_FETCH;
        end else if (is_lw || is_sw) begin
          state_next = ea_misaligned ? S_HALT : S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = ADDR_W'(alu_reg);
        if (mem_ready) begin
          retire     = is_sw;
          state_next = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg  <= RESET_PC;
      npc_reg <= RESET_PC;
      ir_reg  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      alu_reg <= '0;
      mdr_reg <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            ir_reg  <= mem_rdata;
            npc_reg <= pc_reg + ADDR_W'(4);
          end
        end
        S_DECODE: begin
          a_reg   <= rs_val;
          b_reg   <= rt_val;
          imm_reg <= ext_imm;
        end
        S_EXEC: begin
          alu_reg <= alu_next;
          if (is_beq || is_bne)
            pc_reg <= branch_taken ? branch_target : npc_reg;
          else if (is_j || is_jal)
            pc_reg <= jump_target;
          else if (is_jr && !jr_misaligned)
            pc_reg <= ADDR_W'(a_reg);
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_sw) pc_reg  <= npc_reg;
            else       mdr_reg <= mem_rdata;
          end
        end
        S_WB: begin
          if (wb_dst != 5'd0) regs[wb_dst] <= wb_data;
          if (!is_jal) pc_reg <= npc_reg;
        end
        default: ;
      endcase
    end
  end

  assign PCOut        = pc_reg;
  assign ALUResultOut = alu_reg;

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multi-cycle MIPS32 subset core with a single unified, wait-state-tolerant memory port. Each instruction walks a FETCH/DECODE/EXEC/MEM/WB state machine and shares one ALU and one memory interface. It replaces the single-cycle datapath wherever instruction and data memory sit behind one slow or shared bus. It adds memory handshaking, a parametrised reset vector and address width, a retire pulse and a halt-on-illegal state.

## Interface
- `ADDR_W`, default 32: width of `mem_addr` and PC; PC arithmetic wraps modulo 2^ADDR_W.
- `RESET_PC`, default 0: PC value loaded on reset; must be word-aligned.
- `clock` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_req` output 1: memory request valid.
- `mem_we` output 1: 1 = store, 0 = load/fetch; valid while `mem_req`.
- `mem_addr` output ADDR_W: word-aligned byte address.
- `mem_wdata` output 32: store data.
- `mem_rdata` input 32: read data, sampled when `mem_req & mem_ready`.
- `mem_ready` input 1: completes the current request this cycle.
- `PCOut` output ADDR_W: current PC (address of the instruction being fetched or executed).
- `ALUResultOut` output 32: ALU output register.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `halted` output 1: core stopped in HALT.

## Operation
- Supported instructions:
  - R-type: add, sub, and, or, slt, jr.
  - I-type: addi, andi, ori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Everything else is illegal.
- Add/sub are modulo 2^32 with no overflow trap. slt/slti compare signed.
- Immediate extension: andi/ori zero-extend; all other immediates sign-extend.
- Register file: 32×32; `$0` reads 0 and ignores writes. Two combinational reads, one write port, writes only in WB.
- State machine, reset state FETCH:
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. Stay until `mem_ready`. On `mem_ready`: IR←`mem_rdata`, NPC←PC+4, go to DECODE.
  - DECODE: A←rs, B←rt, imm extended. An illegal opcode or funct goes to HALT; otherwise go to EXEC.
  - EXEC: ALUResult←op(A, B or imm). Exits depend on the instruction:
    - beq/bne: PC←NPC+(simm<<2) if taken, else PC←NPC; retire; go to FETCH.
    - j: PC←{NPC[top 4 bits], target, 00}; retire; go to FETCH.
    - jal: same PC update, then go to WB with link value NPC.
    - jr: PC←A; retire; go to FETCH. A misaligned A (A[1:0]≠0) goes to HALT instead.
    - lw/sw: go to MEM. A misaligned effective address goes to HALT instead.
    - All others: go to WB.
  - MEM: `mem_req`=1, `mem_addr`=ALUResult, `mem_we`=sw, `mem_wdata`=B. Stay until `mem_ready`.
    - sw: PC←NPC, retire, go to FETCH.
    - lw: MDR←`mem_rdata`, go to WB.
  - WB: write the destination register, then PC←NPC (except jal, whose PC was already set), retire, go to FETCH.
    - Destination: rd for R-type, rt for I-type, 31 for jal.
    - Data: MDR for lw, {imm,16'h0} for lui, NPC for jal, ALUResult otherwise.
  - HALT: `halted`=1, `mem_req`=0. Only `reset` exits.
- While `mem_req` is high, `mem_addr`, `mem_we` and `mem_wdata` stay stable until `mem_ready`.

## Timing
- Reset values: PC=`RESET_PC`; all registers, IR, A, B, MDR and ALUResult are 0; `mem_req`=1 (FETCH); `mem_we`=0; `retire`=0; `halted`=0.
- Latency with zero wait states (`mem_ready` high in the first request cycle):
  - beq, bne, j, jr: 3 cycles.
  - R-type, I-type ALU, lui, jal: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle on `mem_ready` adds one cycle in FETCH or MEM.
- `mem_ready` while `mem_req`=0 is ignored.
- `retire` pulses in the final cycle of an instruction; PC holds the new value from the next cycle.
- Reset asserted in any state, including mid-request, aborts the instruction. The next cycle is FETCH at `RESET_PC` with no register write.
- A register write in WB is visible to DECODE of the next instruction; no forwarding is needed.

## Test plan
- Reset, then `mem_ready` held 1 with fetch returning `addi $1,$0,5`: `mem_addr`=0 in the first cycle; `retire` in cycle 4; `$1`=5; PCOut=4.
- FETCH with `mem_ready` low for 3 cycles: `mem_req` and `mem_addr` stay stable for all 4 cycles; the instruction retires 3 cycles later than the zero-wait case.
- `addi $2,$0,0x40`, then `sw $1,0($2)`, then `lw $3,0($2)`: the store cycle shows `mem_we`=1, `mem_addr`=0x40, `mem_wdata`=5; `$3`=5; lw takes 5 cycles.
- `beq $0,$0,-1` at 0x10: PC returns to 0x10 after 3 cycles. `bne $0,$0,8`: PC=0x14.
- `jal` to 0x100, then `jr $31`: `$31`=PC_jal+4 and execution resumes there. `lui $4,0x1234` gives `$4`=0x12340000. `addi $0,$0,7` leaves `$0`=0.
- Opcode 0x3F: `halted`=1 and `mem_req`=0 permanently. Reset asserted mid-MEM wait: the next cycle is FETCH at `RESET_PC` with no write.
